// File: rtl/pixel_cfg_clk_ctrl.sv
// Pixel-config shift clock sequencer: programmable divider that emits bursts of N-cycle
// periods (or free-runs) with registered clkout plus rise/fall strobes in the clkin domain.
module pixel_cfg_clk_ctrl #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 5
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_load,
    output logic             cfg_err,
    output logic [DIV_W-1:0] div_active,
    input  logic             start,
    input  logic [CNT_W-1:0] n_cycles,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic             clkout,
    output logic             rise_stb,
    output logic             fall_stb
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] ph_cnt_q, ph_cnt_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [DIV_W-1:0] div_lat_q, div_lat_d;
    logic [CNT_W-1:0] ncyc_q, ncyc_d;
    logic             stop_pend_q, stop_pend_d;
    logic [DIV_W-1:0] div_active_q, div_active_d;
    logic             clkout_q, clkout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             cfg_err_q, cfg_err_d;

    logic             idle;
    logic             load_ok;
    logic [DIV_W-1:0] h_len;
    logic [DIV_W-1:0] l_len;
    logic [CNT_W-1:0] per_inc;
    logic [CNT_W-1:0] per_sat;
    logic             last_per;

    always_comb begin
        idle     = (state_q == IDLE);
        load_ok  = cfg_load && idle && (cfg_div >= DIV_W'(2));
        // High phase gets the extra cycle for odd ratios.
        h_len    = (div_lat_q >> 1) + {{(DIV_W-1){1'b0}}, div_lat_q[0]};
        l_len    = div_lat_q >> 1;
        per_inc  = per_cnt_q + CNT_W'(1);
        per_sat  = (&per_cnt_q) ? per_cnt_q : per_inc;
        last_per = (ncyc_q != '0) && (per_inc == ncyc_q);
    end

    always_comb begin
        state_d      = state_q;
        ph_cnt_d     = ph_cnt_q;
        per_cnt_d    = per_cnt_q;
        div_lat_d    = div_lat_q;
        ncyc_d       = ncyc_q;
        stop_pend_d  = stop_pend_q;
        clkout_d     = clkout_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        cfg_err_d    = cfg_load && !load_ok;
        div_active_d = load_ok ? cfg_div : div_active_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = HIGH;
                    ph_cnt_d    = '0;
                    per_cnt_d   = '0;
                    // A same-cycle accepted load takes effect for this burst.
                    div_lat_d   = load_ok ? cfg_div : div_active_q;
                    ncyc_d      = n_cycles;
                    stop_pend_d = 1'b0;
                    clkout_d    = 1'b1;
                    rise_d      = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            HIGH: begin
                stop_pend_d = stop_pend_q | stop;
                if (ph_cnt_q == h_len - DIV_W'(1)) begin
                    state_d  = LOW;
                    ph_cnt_d = '0;
                    clkout_d = 1'b0;
                    fall_d   = 1'b1;
                end else begin
                    ph_cnt_d = ph_cnt_q + DIV_W'(1);
                end
            end
            LOW: begin
                stop_pend_d = stop_pend_q | stop;
                if (ph_cnt_q == l_len - DIV_W'(1)) begin
                    per_cnt_d = per_sat;
                    ph_cnt_d  = '0;
                    if (last_per || stop_pend_q || stop) begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        clkout_d    = 1'b0;
                    end else begin
                        state_d  = HIGH;
                        clkout_d = 1'b1;
                        rise_d   = 1'b1;
                    end
                end else begin
                    ph_cnt_d = ph_cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                clkout_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q      <= IDLE;
            ph_cnt_q     <= '0;
            per_cnt_q    <= '0;
            div_lat_q    <= DIV_W'(DEFAULT_DIV);
            ncyc_q       <= '0;
            stop_pend_q  <= 1'b0;
            div_active_q <= DIV_W'(DEFAULT_DIV);
            clkout_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_cnt_q     <= ph_cnt_d;
            per_cnt_q    <= per_cnt_d;
            div_lat_q    <= div_lat_d;
            ncyc_q       <= ncyc_d;
            stop_pend_q  <= stop_pend_d;
            div_active_q <= div_active_d;
            clkout_q     <= clkout_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign cfg_err    = cfg_err_q;
    assign div_active = div_active_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign clkout     = clkout_q;
    assign rise_stb   = rise_q;
    assign fall_stb   = fall_q;

endmodule

// File: tb/tb_pixel_cfg_clk_ctrl.sv
// Directed bench for pixel_cfg_clk_ctrl: table of bursts plus hand sequences for
// load rejection, free-run stop and mid-burst reset.
module tb_pixel_cfg_clk_ctrl;

    logic        clkin;
    logic        rst;
    logic [7:0]  cfg_div;
    logic        cfg_load;
    logic        cfg_err;
    logic [7:0]  div_active;
    logic        start;
    logic [15:0] n_cycles;
    logic        stop;
    logic        busy;
    logic        done;
    logic        clkout;
    logic        rise_stb;
    logic        fall_stb;

    int total;
    int bad;

    pixel_cfg_clk_ctrl #(
        .DIV_W      (8),
        .CNT_W      (16),
        .DEFAULT_DIV(5)
    ) dut (
        .clkin     (clkin),
        .rst       (rst),
        .cfg_div   (cfg_div),
        .cfg_load  (cfg_load),
        .cfg_err   (cfg_err),
        .div_active(div_active),
        .start     (start),
        .n_cycles  (n_cycles),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .clkout    (clkout),
        .rise_stb  (rise_stb),
        .fall_stb  (fall_stb)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    typedef struct {
        logic        pre_load;
        logic        same_load;
        logic [7:0]  div;
        logic [15:0] ncyc;
        int          exp_n;
        int          exp_k;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic start_burst(input logic ld, input logic [7:0] dv, input logic [15:0] nc);
        start    = 1'b1;
        n_cycles = nc;
        cfg_load = ld;
        cfg_div  = dv;
        step();
        start    = 1'b0;
        cfg_load = 1'b0;
    endtask

    // Called in cycle t+1 after start; walks k periods of ratio n plus the done cycle.
    task automatic check_burst(input int n, input int k);
        int h;
        int p;
        h = (n + 1) / 2;
        for (int c = 1; c <= k * n + 1; c++) begin
            if (c <= k * n) begin
                p = (c - 1) % n;
                chk("clkout", int'(clkout), (p < h) ? 1 : 0);
                chk("rise", int'(rise_stb), (p == 0) ? 1 : 0);
                chk("fall", int'(fall_stb), (p == h) ? 1 : 0);
                chk("busy", int'(busy), 1);
                chk("done_early", int'(done), 0);
            end else begin
                chk("end_clkout", int'(clkout), 0);
                chk("end_rise", int'(rise_stb), 0);
                chk("end_fall", int'(fall_stb), 0);
                chk("end_busy", int'(busy), 0);
                chk("done", int'(done), 1);
            end
            step();
        end
        chk("done_pulse", int'(done), 0);
    endtask

    initial begin
        int rises;
        int done_c;
        vec_t v;

        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        cfg_div  = '0;
        cfg_load = 1'b0;
        start    = 1'b0;
        n_cycles = '0;
        stop     = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 8'd0, 16'd3, 5, 3, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 8'd4, 16'd2, 4, 2, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 8'd3, 16'd1, 3, 1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 8'd1, 16'd1, 3, 1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 8'd2, 16'd3, 2, 3, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 8'd7, 16'd2, 7, 2, 1'b0};

        step();
        step();
        chk("rst_div", int'(div_active), 5);
        chk("rst_clkout", int'(clkout), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(cfg_err), 0);
        chk("rst_rise", int'(rise_stb), 0);
        chk("rst_fall", int'(fall_stb), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            if (v.pre_load) begin
                cfg_load = 1'b1;
                cfg_div  = v.div;
                step();
                cfg_load = 1'b0;
                chk("pre_err", int'(cfg_err), int'(v.exp_err));
                chk("pre_div", int'(div_active), v.exp_n);
            end
            start_burst(v.same_load, v.div, v.ncyc);
            chk("start_err", int'(cfg_err), v.same_load ? int'(v.exp_err) : 0);
            check_burst(v.exp_n, v.exp_k);
            step();
        end

        // Ratio below 2 rejected in IDLE.
        cfg_load = 1'b1;
        cfg_div  = 8'd1;
        step();
        cfg_load = 1'b0;
        chk("low_err", int'(cfg_err), 1);
        chk("low_div", int'(div_active), 7);
        step();
        chk("err_pulse", int'(cfg_err), 0);

        cfg_load = 1'b1;
        cfg_div  = 8'd5;
        step();
        cfg_load = 1'b0;
        chk("div5", int'(div_active), 5);

        // Load and restart while busy are both ignored; burst ends on schedule.
        start_burst(1'b0, 8'd0, 16'd2);
        step();
        cfg_load = 1'b1;
        cfg_div  = 8'd8;
        step();
        cfg_load = 1'b0;
        chk("busy_err", int'(cfg_err), 1);
        chk("busy_div", int'(div_active), 5);
        start    = 1'b1;
        n_cycles = 16'd9;
        done_c   = 0;
        for (int c = 3; c <= 40; c++) begin
            if (done) begin
                done_c = c;
                break;
            end
            step();
            start = 1'b0;
        end
        start = 1'b0;
        chk("busy_done_cycle", done_c, 11);
        step();
        chk("busy_idle", int'(busy), 0);

        // Free-run, stop in second cycle of the 4th period.
        start_burst(1'b0, 8'd0, 16'd0);
        rises  = 0;
        done_c = 0;
        for (int c = 1; c <= 60; c++) begin
            if (rise_stb) rises++;
            if (rise_stb && fall_stb) chk("rise_fall_excl", 1, 0);
            if (done) begin
                done_c = c;
                chk("fr_clkout", int'(clkout), 0);
                chk("fr_busy", int'(busy), 0);
                break;
            end
            stop = (c == 17);
            step();
        end
        stop = 1'b0;
        chk("fr_rises", rises, 4);
        chk("fr_done_cycle", done_c, 21);
        step();
        chk("fr_done_pulse", int'(done), 0);

        // Stop in IDLE must not affect the next burst.
        stop = 1'b1;
        step();
        stop = 1'b0;

        // Reset mid-HIGH aborts without done and restores the default ratio.
        cfg_load = 1'b1;
        cfg_div  = 8'd7;
        step();
        cfg_load = 1'b0;
        chk("pre_rst_div", int'(div_active), 7);
        start_burst(1'b0, 8'd0, 16'd3);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_clkout", int'(clkout), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_div", int'(div_active), 5);
        rises = 0;
        for (int c = 0; c < 8; c++) begin
            if (done || busy || rise_stb) rises++;
            step();
        end
        chk("abort_quiet", rises, 0);
        start_burst(1'b0, 8'd0, 16'd3);
        check_burst(5, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
